// File: rtl/gpio_clk_sched_pkg.sv
// Shared constants and FSM encoding for the divided-clock scheduler.
package gpio_clk_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 24;
    localparam int DEF_LEN_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gpio_clk_sched_if.sv
// Requester/scheduler signal bundle; master drives requests, slave answers.
interface gpio_clk_sched_if #(
    parameter int NUM_REQ = gpio_clk_pkg::DEF_NUM_REQ,
    parameter int WIDTH   = gpio_clk_pkg::DEF_WIDTH,
    parameter int LEN_W   = gpio_clk_pkg::DEF_LEN_W
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0][WIDTH-1:0] div;
    logic [NUM_REQ-1:0][LEN_W-1:0] len;
    logic [NUM_REQ-1:0]            grant;
    logic                          sclk;
    logic                          sclk_rise;
    logic                          sclk_fall;
    logic                          busy;
    logic [NUM_REQ-1:0]            done;
    logic                          aborted;

    modport master (
        output req, div, len,
        input  grant, sclk, sclk_rise, sclk_fall, busy, done, aborted
    );
    modport slave (
        input  req, div, len,
        output grant, sclk, sclk_rise, sclk_fall, busy, done, aborted
    );
endinterface

// File: rtl/gpio_div_tick.sv
// Half-period down-counter: tc fires on the enabled cycle where the count is zero,
// and the counter reloads itself on that same edge.
module gpio_div_tick #(
    parameter int WIDTH = gpio_clk_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] cnt;

    assign tc = en && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= tc ? load_val : cnt - 1'b1;
    end
endmodule

// File: rtl/gpio_clk_sched.sv
// Round-robin arbiter handing one shared divided clock (sclk) to a requester
// for a burst of len full periods, with abort on request drop.
module gpio_clk_sched
    import gpio_clk_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    gpio_clk_sched_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_grant, gnt_idx, win_idx, cand;
    logic               win_vld;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]   div_r, load_val;
    logic [LEN_W-1:0]   len_r, fall_cnt;
    logic               sclk, sclk_rise, sclk_fall, aborted_r;
    logic               take, cnt_load, cnt_en, tc, tog, abort;

    // A divisor of 0 behaves as 1, i.e. a reload value of 0.
    function automatic logic [WIDTH-1:0] half_reload(input logic [WIDTH-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // Search starts one past the last winner and wraps.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign load_val = (state == IDLE) ? half_reload(bus.div[win_idx]) : half_reload(div_r);

    gpio_div_tick #(.WIDTH(WIDTH)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (load_val),
        .tc       (tc)
    );

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        tog       = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: if (win_vld) begin
                take      = 1'b1;
                cnt_load  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (!bus.req[gnt_idx]) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end else if (len_r == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_en = 1'b1;
                    if (tc) begin
                        tog = 1'b1;
                        if (sclk && (fall_cnt + 1'b1) == len_r) state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            gnt_idx    <= '0;
            grant      <= '0;
            div_r      <= '0;
            len_r      <= '0;
            fall_cnt   <= '0;
            sclk       <= 1'b0;
            sclk_rise  <= 1'b0;
            sclk_fall  <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            aborted_r <= 1'b0;
            if (take) begin
                gnt_idx  <= win_idx;
                grant    <= NUM_REQ'(1) << win_idx;
                div_r    <= bus.div[win_idx];
                len_r    <= bus.len[win_idx];
                fall_cnt <= '0;
                sclk     <= 1'b0;
            end
            if (tog) begin
                sclk      <= ~sclk;
                sclk_rise <= ~sclk;
                sclk_fall <= sclk;
                if (sclk) fall_cnt <= fall_cnt + 1'b1;
            end
            // Abort parks sclk low silently: no fall pulse for the cut-short phase.
            if (abort) begin
                sclk      <= 1'b0;
                aborted_r <= 1'b1;
            end
            if (state == DONE) begin
                grant      <= '0;
                last_grant <= gnt_idx;
            end
        end
    end

    assign bus.grant     = grant;
    assign bus.sclk      = sclk;
    assign bus.sclk_rise = sclk_rise;
    assign bus.sclk_fall = sclk_fall;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE) ? grant : '0;
    assign bus.aborted   = aborted_r;
endmodule

// File: tb/tb_gpio_clk_sched.sv
// Directed bench for gpio_clk_sched: burst timing, round-robin, abort, degenerate values, reset.
module tb_gpio_clk_sched;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    gpio_clk_sched_if #(.NUM_REQ(4), .WIDTH(24), .LEN_W(16)) bus ();

    gpio_clk_sched #(.NUM_REQ(4), .WIDTH(24), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.div = '0;
        bus.len = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 4'b1111;
        bus.div = '0;
        bus.len = '0;
        step();
        step();
        n_cmp++;
        if ({bus.grant, bus.sclk, bus.sclk_rise, bus.sclk_fall, bus.busy, bus.done, bus.aborted} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {bus.grant, bus.sclk, bus.sclk_rise,
                     bus.sclk_fall, bus.busy, bus.done, bus.aborted});
        end
        bus.req = '0;
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int gcnt = 0, rises = 0, falls = 0, done_c = 0, sclk_bad = 0, first_g = 0;
        logic ab = 1'bx;
        logic exp_s;
        do_reset();
        bus.div[0] = 24'd2;
        bus.len[0] = 16'd3;
        bus.req    = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.grant[0]) begin
                gcnt++;
                if (first_g == 0) first_g = c;
            end
            if (bus.sclk_rise) rises++;
            if (bus.sclk_fall) falls++;
            exp_s = (c >= 3 && c <= 12 && ((c - 3) % 4) < 2);
            if (c <= 14 && bus.sclk !== exp_s) sclk_bad++;
            if (bus.sclk_rise && !bus.sclk) sclk_bad++;
            if (bus.done[0]) begin
                done_c  = c;
                ab      = bus.aborted;
                bus.req = '0;
            end
        end
        n_cmp++; if (first_g != 1)  begin n_err++; $display("FAIL basic_first_grant: got %0d want 1", first_g); end
        n_cmp++; if (gcnt != 13)    begin n_err++; $display("FAIL basic_grant_len: got %0d want 13", gcnt); end
        n_cmp++; if (rises != 3)    begin n_err++; $display("FAIL basic_rises: got %0d want 3", rises); end
        n_cmp++; if (falls != 3)    begin n_err++; $display("FAIL basic_falls: got %0d want 3", falls); end
        n_cmp++; if (sclk_bad != 0) begin n_err++; $display("FAIL basic_sclk_shape: got %0d bad cycles want 0", sclk_bad); end
        n_cmp++; if (done_c != 13)  begin n_err++; $display("FAIL basic_done_cycle: got %0d want 13", done_c); end
        n_cmp++; if (ab !== 1'b0)   begin n_err++; $display("FAIL basic_aborted: got %b want 0", ab); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_end_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int bad = 0, dones = 0, multi = 0;
        logic [3:0] exp_g;
        do_reset();
        bus.div[0] = 24'd1; bus.len[0] = 16'd1;
        bus.div[2] = 24'd1; bus.len[2] = 16'd1;
        bus.req    = 4'b0101;
        for (int c = 1; c <= 16; c++) begin
            step();
            exp_g = (c % 4 == 0) ? 4'b0000 : ((((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0100);
            if (bus.grant !== exp_g) bad++;
            if ($countones(bus.grant) > 1) multi++;
            if (bus.done != 4'b0000) dones++;
        end
        bus.req = '0;
        n_cmp++; if (bad != 0)   begin n_err++; $display("FAIL rr_grant_sequence: got %0d bad cycles want 0", bad); end
        n_cmp++; if (multi != 0) begin n_err++; $display("FAIL rr_onehot: got %0d multi-grant cycles want 0", multi); end
        n_cmp++; if (dones != 4) begin n_err++; $display("FAIL rr_done_count: got %0d want 4", dones); end
    endtask

    task automatic test_abort();
        do_reset();
        bus.div[1] = 24'd4;
        bus.len[1] = 16'd5;
        bus.req    = 4'b0010;
        for (int c = 1; c <= 10; c++) step();
        bus.req = '0;
        step();
        n_cmp++; if (bus.done !== 4'b0010) begin n_err++; $display("FAIL abort_done: got %b want 0010", bus.done); end
        n_cmp++; if (bus.aborted !== 1'b1) begin n_err++; $display("FAIL abort_flag: got %b want 1", bus.aborted); end
        n_cmp++; if (bus.sclk !== 1'b0)    begin n_err++; $display("FAIL abort_sclk: got %b want 0", bus.sclk); end
        n_cmp++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL abort_grant_held: got %b want 0010", bus.grant); end
        step();
        n_cmp++; if ({bus.grant, bus.busy, bus.aborted} !== 6'd0) begin
            n_err++; $display("FAIL abort_clear: got %b want 0", {bus.grant, bus.busy, bus.aborted});
        end

        // Abort while sclk is high: forced low without a fall pulse.
        do_reset();
        bus.div[1] = 24'd4;
        bus.len[1] = 16'd5;
        bus.req    = 4'b0010;
        for (int c = 1; c <= 6; c++) step();
        n_cmp++; if (bus.sclk !== 1'b1) begin n_err++; $display("FAIL abort_hi_pre_sclk: got %b want 1", bus.sclk); end
        bus.req = '0;
        step();
        n_cmp++; if ({bus.sclk, bus.sclk_fall, bus.aborted} !== 3'b001) begin
            n_err++; $display("FAIL abort_hi_state: sclk/fall/aborted got %b want 001", {bus.sclk, bus.sclk_fall, bus.aborted});
        end
        step();
    endtask

    task automatic test_degenerate();
        int gcnt = 0, rises = 0, falls = 0, done_c = 0, bad = 0, edges = 0;
        logic ab = 1'bx;
        logic [4:0] exp_s = 5'b01010;
        do_reset();
        bus.div[0] = 24'd0;
        bus.len[0] = 16'd2;
        bus.req    = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                bus.div[0] = 24'd9;
                bus.len[0] = 16'd7;
            end
            if (bus.grant[0]) gcnt++;
            if (bus.sclk_rise) rises++;
            if (bus.sclk_fall) falls++;
            if (c <= 5 && bus.sclk !== exp_s[5-c]) bad++;
            if (bus.done[0]) begin done_c = c; bus.req = '0; end
        end
        n_cmp++; if (gcnt != 5)   begin n_err++; $display("FAIL div0_grant_len: got %0d want 5", gcnt); end
        n_cmp++; if (rises != 2)  begin n_err++; $display("FAIL div0_rises: got %0d want 2", rises); end
        n_cmp++; if (falls != 2)  begin n_err++; $display("FAIL div0_falls: got %0d want 2", falls); end
        n_cmp++; if (bad != 0)    begin n_err++; $display("FAIL div0_sclk_shape: got %0d bad cycles want 0", bad); end
        n_cmp++; if (done_c != 5) begin n_err++; $display("FAIL div0_done_cycle: got %0d want 5", done_c); end

        do_reset();
        gcnt = 0; done_c = 0;
        bus.div[0] = 24'd5;
        bus.len[0] = 16'd0;
        bus.req    = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (bus.grant[0]) gcnt++;
            if (bus.sclk || bus.sclk_rise || bus.sclk_fall) edges++;
            if (bus.done[0]) begin done_c = c; ab = bus.aborted; bus.req = '0; end
        end
        n_cmp++; if (gcnt != 2)   begin n_err++; $display("FAIL len0_grant_len: got %0d want 2", gcnt); end
        n_cmp++; if (done_c != 2) begin n_err++; $display("FAIL len0_done_cycle: got %0d want 2", done_c); end
        n_cmp++; if (edges != 0)  begin n_err++; $display("FAIL len0_sclk_activity: got %0d want 0", edges); end
        n_cmp++; if (ab !== 1'b0) begin n_err++; $display("FAIL len0_aborted: got %b want 0", ab); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        do_reset();
        // Short burst on index 0 so last_grant moves off its reset value.
        bus.div[0] = 24'd1;
        bus.len[0] = 16'd1;
        bus.req    = 4'b0001;
        for (int c = 1; c <= 3; c++) step();
        bus.req = '0;
        step();
        bus.div[1] = 24'd3;
        bus.len[1] = 16'd4;
        bus.req    = 4'b0010;
        for (int c = 1; c <= 7; c++) step();
        n_cmp++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL rmid_pre_grant: got %b want 0010", bus.grant); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.grant, bus.sclk, bus.sclk_rise, bus.sclk_fall, bus.busy, bus.done, bus.aborted} !== 13'd0) begin
            n_err++;
            $display("FAIL rmid_async_zero: got %b want 0", {bus.grant, bus.sclk, bus.sclk_rise,
                     bus.sclk_fall, bus.busy, bus.done, bus.aborted});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (bus.done != 4'b0000) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
        rst     = 1'b0;
        bus.div[0] = 24'd2; bus.len[0] = 16'd1;
        bus.div[3] = 24'd2; bus.len[3] = 16'd1;
        bus.req = 4'b1001;
        step();
        n_cmp++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL rmid_priority: got %b want 0001", bus.grant); end
        bus.req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_abort();
        test_degenerate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gpio_clk_sched.md
GPIO_CLK_SCHED -- requirements
Module: gpio_clk_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the divided-clock resource.
REQ-002 SHALL have parameter WIDTH, default 24: divisor width.
REQ-003 SHALL have parameter LEN_W, default 16: burst-length width, in sclk periods.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester request, level-sensitive, held for the whole burst.
REQ-007 div  input  NUM_REQ x WIDTH  per-requester half-period in clk cycles.
REQ-008 len  input  NUM_REQ x LEN_W  per-requester burst length in full sclk periods.
REQ-009 grant  output  NUM_REQ  one-hot grant; all zero when not busy.
REQ-010 sclk  output  1  shared divided clock, registered, idles low.
REQ-011 sclk_rise  output  1  one-cycle pulse in the first cycle sclk is high.
REQ-012 sclk_fall  output  1  one-cycle pulse in the first cycle sclk is low after a high phase.
REQ-013 busy  output  1  high in the RUN and DONE states.
REQ-014 done  output  NUM_REQ  one-cycle pulse on the granted index in the DONE state.
REQ-015 aborted  output  1  qualifies done: burst terminated by req deassertion.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, with no other states.
REQ-017 In IDLE, any req bit SHALL select a winner by round-robin: the search starts at last_grant+1 and wraps modulo NUM_REQ.
REQ-018 On the IDLE edge with a winner, the block SHALL:
- register div and len of the winner (later changes ignored until the next grant);
- assert grant[winner];
- load the counter with max(div,1)-1;
- set sclk=0 and enter RUN.
REQ-019 A divisor of 0 SHALL behave exactly as 1.
REQ-020 In RUN, the counter SHALL decrement each cycle; at count==0, sclk SHALL toggle on that edge and the counter SHALL reload max(div,1)-1.
REQ-021 First rise timing: sclk SHALL first be high max(div,1) cycles after the first grant cycle; each sclk phase SHALL last exactly max(div,1) cycles.
REQ-022 A fall counter SHALL increment on each high-to-low toggle of sclk.
- The edge producing fall number len SHALL also move the FSM to DONE.
- sclk SHALL be low in DONE.
REQ-023 len==0 SHALL move RUN to DONE on the first RUN edge, with no sclk edges and aborted=0.
REQ-024 If req[granted] is low during RUN, the next edge SHALL:
- enter DONE;
- force sclk low, with no sclk_fall pulse if sclk was high;
- set aborted=1 for the DONE cycle.
REQ-025 DONE SHALL last one cycle.
- grant stays asserted through DONE;
- the next edge clears grant, sets last_grant to the winner and enters IDLE.
REQ-026 The minimum gap between bursts SHALL be one IDLE cycle.
- Total grant duration for an unaborted burst SHALL be 2*max(div,1)*len+1 cycles.
REQ-027 Requests arriving during RUN or DONE SHALL wait; they are never lost while held.
REQ-028 At most one grant bit SHALL be high in any cycle.

Reset
REQ-029 While rst is high, outputs SHALL be zero: grant, sclk, sclk_rise, sclk_fall, busy, done and aborted.
REQ-030 While rst is high, the FSM SHALL be IDLE, the counter and fall counter zero, and last_grant NUM_REQ-1, so index 0 has first priority.
REQ-031 Reset mid-burst SHALL take effect asynchronously with no done pulse.

Structure
REQ-032 Package gpio_clk_pkg SHALL hold the state enum and the default parameter constants.
REQ-033 The half-period counter with load/enable SHALL be sub-module gpio_div_tick.
- It outputs a terminal-count pulse.
- Arbitration and the FSM stay in gpio_clk_sched.

Verification
REQ-034 Basic burst: req[0]=1, div=2, len=3.
- Required: grant[0] for 13 cycles; sclk high/low 2 cycles each; 3 sclk_rise and 3 sclk_fall pulses.
- Required: done[0] in cycle 13 after grant rise, with aborted=0.
REQ-035 Round-robin: req[0] and req[2] held high, div=1, len=1.
- Required: grants in order 0,2,0,2; each grant lasts 3 cycles, with 1 idle cycle between.
REQ-036 Abort: req[1] with div=4, len=5; drop req[1] in cycle 10 of grant.
- Required: the next cycle shows DONE, done[1]=1, aborted=1 and sclk=0; grant clears one cycle later.
REQ-037 Degenerate values: div=0 with len=2 gives sclk toggling every cycle, 2 rises and a grant of 5 cycles; len=0 gives done after 2 grant cycles with no sclk edges.
REQ-038 Reset mid-burst: assert rst in cycle 7 of a div=3, len=4 burst.
- Required: immediate zero outputs.
- Required: after release, a fresh req[3] with req[0] high grants index 0 first.
